// File: rtl/out_port_fifo.sv
// Output-port FIFO: queues core output moves and drains them to a consumer over valid/ready.
// Sticky overflow flag records any write dropped while the queue was full.
module out_port_fifo #(
    parameter int Data_Size  = 16,
    parameter int Depth_Log2 = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  Wr_En,
    input  logic [Data_Size-1:0]  Wr_Data,
    output logic                  Out_Valid,
    output logic [Data_Size-1:0]  Out_Data,
    input  logic                  Out_Ready,
    output logic                  Full,
    output logic [Depth_Log2:0]   Count,
    output logic                  Overflow,
    input  logic                  Clr_Overflow
);

    localparam int DEPTH = 1 << Depth_Log2;
    localparam logic [Depth_Log2:0]   DEPTH_CNT = {1'b1, {Depth_Log2{1'b0}}};
    localparam logic [Depth_Log2-1:0] PTR_ONE   = {{(Depth_Log2-1){1'b0}}, 1'b1};
    localparam logic [Depth_Log2:0]   CNT_ONE   = {{Depth_Log2{1'b0}}, 1'b1};

    logic [Data_Size-1:0]  mem [DEPTH];
    logic [Depth_Log2-1:0] rd_ptr_reg, rd_ptr_next;
    logic [Depth_Log2-1:0] wr_ptr_reg, wr_ptr_next;
    logic [Depth_Log2:0]   count_reg, count_next;
    logic                  overflow_reg, overflow_next;
    logic                  pop, push, drop;

    assign Out_Valid = (count_reg != '0);
    assign Full      = (count_reg == DEPTH_CNT);
    assign Count     = count_reg;
    assign Overflow  = overflow_reg;
    // Masked when empty so stale, never-reset storage is not visible.
    assign Out_Data  = Out_Valid ? mem[rd_ptr_reg] : '0;

    assign pop  = Out_Valid && Out_Ready;
    assign push = Wr_En && (!Full || pop);
    assign drop = Wr_En && Full && !pop;

    always_comb begin
        rd_ptr_next   = rd_ptr_reg;
        wr_ptr_next   = wr_ptr_reg;
        count_next    = count_reg;
        overflow_next = overflow_reg;
        if (pop) begin
            rd_ptr_next = rd_ptr_reg + PTR_ONE;
        end
        if (push) begin
            wr_ptr_next = wr_ptr_reg + PTR_ONE;
        end
        if (push && !pop) begin
            count_next = count_reg + CNT_ONE;
        end else if (pop && !push) begin
            count_next = count_reg - CNT_ONE;
        end
        // A drop in the same cycle as a clear keeps the flag set.
        if (drop) begin
            overflow_next = 1'b1;
        end else if (Clr_Overflow) begin
            overflow_next = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_reg   <= '0;
            wr_ptr_reg   <= '0;
            count_reg    <= '0;
            overflow_reg <= 1'b0;
        end else begin
            rd_ptr_reg   <= rd_ptr_next;
            wr_ptr_reg   <= wr_ptr_next;
            count_reg    <= count_next;
            overflow_reg <= overflow_next;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !rst) begin
            mem[wr_ptr_reg] <= Wr_Data;
        end
    end

endmodule

// File: tb/tb_out_port_fifo.sv
// Scoreboard bench for out_port_fifo: stimulus queues expected words, a negedge monitor checks each pop.
module tb_out_port_fifo;

    logic        clk;
    logic        rst;
    logic        Wr_En;
    logic [15:0] Wr_Data;
    logic        Out_Valid;
    logic [15:0] Out_Data;
    logic        Out_Ready;
    logic        Full;
    logic [3:0]  Count;
    logic        Overflow;
    logic        Clr_Overflow;

    int checks = 0;
    int errors = 0;
    logic [15:0] exp_q[$];

    out_port_fifo #(.Data_Size(16), .Depth_Log2(3)) dut (
        .clk(clk),
        .rst(rst),
        .Wr_En(Wr_En),
        .Wr_Data(Wr_Data),
        .Out_Valid(Out_Valid),
        .Out_Data(Out_Data),
        .Out_Ready(Out_Ready),
        .Full(Full),
        .Count(Count),
        .Overflow(Overflow),
        .Clr_Overflow(Clr_Overflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (act=timeout, req=finish)");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end else begin
            $display("check %s: %0h ok", name, act);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive one write for a cycle; accept says whether the hand analysis expects it queued.
    task automatic push(input logic [15:0] d, input bit accept);
        Wr_En   = 1'b1;
        Wr_Data = d;
        if (accept) exp_q.push_back(d);
        $display("push %h expect_%s", d, accept ? "accept" : "drop");
        step();
        Wr_En = 1'b0;
    endtask

    // Monitor: a pop happens at the next rising edge whenever valid and ready are both high.
    always @(negedge clk) begin
        if (!rst && Out_Valid && Out_Ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL pop_unexpected: got %h, expected no word", Out_Data);
            end else begin
                logic [15:0] e;
                e = exp_q.pop_front();
                if (Out_Data !== e) begin
                    errors++;
                    $display("FAIL pop_data: got %h, expected %h", Out_Data, e);
                end else begin
                    $display("pop %h ok", Out_Data);
                end
            end
        end
    end

    initial begin
        rst = 1'b1; Wr_En = 1'b0; Wr_Data = '0; Out_Ready = 1'b0; Clr_Overflow = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Fill past full so reset has something to clear, then reset mid-cycle.
        for (int i = 0; i < 8; i++) push(16'h00F0 + 16'(i), 1'b1);
        push(16'h00F8, 1'b0);
        chk("pre_reset_overflow", 32'(Overflow), 32'd1);
        @(posedge clk);
        #3 rst = 1'b1;
        exp_q.delete();
        #1;
        chk("rst_valid", 32'(Out_Valid), 32'd0);
        chk("rst_data", 32'(Out_Data), 32'd0);
        chk("rst_count", 32'(Count), 32'd0);
        chk("rst_full", 32'(Full), 32'd0);
        chk("rst_overflow", 32'(Overflow), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        Out_Ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("idle_count", 32'(Count), 32'd0);
        end

        // Ordering and latency
        Out_Ready = 1'b0;
        chk("empty_valid", 32'(Out_Valid), 32'd0);
        push(16'h1234, 1'b1);
        chk("lat_valid", 32'(Out_Valid), 32'd1);
        chk("lat_data", 32'(Out_Data), 32'h1234);
        push(16'hABCD, 1'b1);
        push(16'h0001, 1'b1);
        chk("ord_count", 32'(Count), 32'd3);
        chk("ord_head", 32'(Out_Data), 32'h1234);
        Out_Ready = 1'b1;
        step(); step();
        chk("ord_valid_before_last", 32'(Out_Valid), 32'd1);
        step();
        chk("ord_valid_after", 32'(Out_Valid), 32'd0);
        chk("ord_data_after", 32'(Out_Data), 32'd0);
        Out_Ready = 1'b0;

        // Fill and overflow
        for (int i = 0; i < 8; i++) push(16'h0010 + 16'(i), 1'b1);
        chk("fill_full", 32'(Full), 32'd1);
        chk("fill_count", 32'(Count), 32'd8);
        push(16'hDEAD, 1'b0);
        chk("drop_overflow", 32'(Overflow), 32'd1);
        chk("drop_count", 32'(Count), 32'd8);
        Out_Ready = 1'b1;
        repeat (8) step();
        Out_Ready = 1'b0;
        chk("drain_count", 32'(Count), 32'd0);
        chk("drain_overflow_sticky", 32'(Overflow), 32'd1);
        Clr_Overflow = 1'b1;
        step();
        Clr_Overflow = 1'b0;
        chk("clr_overflow", 32'(Overflow), 32'd0);

        // Full with simultaneous push and pop
        for (int i = 0; i < 8; i++) push(16'h0020 + 16'(i), 1'b1);
        Out_Ready = 1'b1;
        push(16'h5555, 1'b1);
        Out_Ready = 1'b0;
        chk("pp_overflow", 32'(Overflow), 32'd0);
        chk("pp_count", 32'(Count), 32'd8);
        Out_Ready = 1'b1;
        repeat (8) step();
        Out_Ready = 1'b0;
        chk("pp_drain_count", 32'(Count), 32'd0);

        // Wrap-around: write every cycle, ready on even cycles. Queue reaches full at
        // cycle 13, so writes on the ready-low cycles 15, 17, 19 are dropped.
        for (int i = 0; i < 20; i++) begin
            Out_Ready = (i % 2 == 0);
            push(16'h0100 + 16'(i), !(i == 15 || i == 17 || i == 19));
        end
        Out_Ready = 1'b0;
        chk("wrap_count", 32'(Count), 32'd8);
        chk("wrap_overflow", 32'(Overflow), 32'd1);

        // Overflow clear priority: drop wins over clear in the same cycle
        Clr_Overflow = 1'b1;
        push(16'hBEEF, 1'b0);
        chk("clr_vs_drop", 32'(Overflow), 32'd1);
        step();
        Clr_Overflow = 1'b0;
        chk("clr_after", 32'(Overflow), 32'd0);
        Out_Ready = 1'b1;
        repeat (8) step();
        Out_Ready = 1'b0;
        chk("final_count", 32'(Count), 32'd0);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
